frame_writer: RTL and testbench
===============================

# frame_writer

Downstream sink for the Sobel pipeline: consumes the `2*WIDTH_P`-bit gradient stream produced by the 2-D convolution stage over a valid/ready handshake. It scales and saturates each gradient to `WIDTH_P` bits and writes it in raster order into a frame memory through a write port with backpressure. It counts pixels per frame, signals frame completion, and throttles the upstream stream whenever the memory stalls or no frame is armed.

## Interface
- `WIDTH_P`, 8: output pixel width; the input gradient width is `2*WIDTH_P`.
- `IMG_W_P`, 16: frame width in pixels.
- `IMG_H_P`, 16: frame height in pixels.
- `SHIFT_P`, 0: right-shift applied to the gradient before saturation; legal range is 0 to `WIDTH_P`.
- `ADDR_W_P`, `$clog2(IMG_W_P*IMG_H_P)`: memory address width (derived).

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rstn_i` in 1: asynchronous active-low reset.
- `start_i` in 1: arms one frame; sampled only in IDLE.
- `valid_i` in 1: upstream gradient valid.
- `ready_o` out 1: upstream ready.
- `data_i` in `2*WIDTH_P`: unsigned gradient magnitude.
- `mem_we_o` out 1: write request valid.
- `mem_ready_i` in 1: memory accepts the write this cycle.
- `mem_addr_o` out `ADDR_W_P`: write address, `y*IMG_W_P + x`.
- `mem_data_o` out `WIDTH_P`: saturated pixel.
- `busy_o` out 1: high in RUN and DRAIN.
- `done_o` out 1: one-cycle frame-complete pulse.

## Operation
- **FSM states: IDLE, RUN, DRAIN.**
  - IDLE → RUN on `start_i`. The pixel counter, `x`, and `y` are cleared at the same edge.
  - RUN → DRAIN on the input handshake of pixel number `IMG_W_P*IMG_H_P-1`, the last pixel of the frame.
  - DRAIN → IDLE when the final write handshake occurs (`mem_we_o && mem_ready_i`).
- **Input handshake:** a transfer occurs when `valid_i && ready_o`.
  - `ready_o = (state==RUN) && (!mem_we_o || mem_ready_i)`. This is a single output register with pass-through on drain, so it sustains one pixel per cycle.
- **Output register:**
  - It loads on each input handshake: `mem_we_o` goes to 1, and `mem_data_o` and `mem_addr_o` are updated.
  - It holds unchanged while `mem_we_o && !mem_ready_i`.
  - It clears `mem_we_o` on a write handshake when no new input arrives.
- **Arithmetic:**
  - `s = data_i >> SHIFT_P`.
  - `mem_data_o = (s > 2^WIDTH_P-1) ? all-ones : s[WIDTH_P-1:0]`.
- **Raster counters:**
  - `x` increments on each input handshake and wraps from `IMG_W_P-1` to 0.
  - `y` increments on the `x` wrap.
  - `mem_addr_o` is registered from the `{y,x}` linear address at handshake time.
- `start_i` in RUN or DRAIN is ignored and has no effect on the counters.
- `valid_i` while in IDLE is not accepted (`ready_o=0`); the data is held upstream.
- **`done_o`:** high for exactly the one cycle after the final write handshake. `busy_o` is 0 in that same cycle.
- **Reset (any time, including mid-frame):**
  - Forces IDLE.
  - Clears the counters.
  - Drives `ready_o=0`, `mem_we_o=0`, `mem_addr_o=0`, `mem_data_o=0`, `busy_o=0`, `done_o=0`.
  - A partially written frame is abandoned, and no `done_o` is issued for it.

## Timing
- `start_i` high at edge N: `busy_o=1` and `ready_o` can be 1 from cycle N+1.
- Input handshake at edge N: `mem_we_o`, `mem_addr_o`, and `mem_data_o` are valid from cycle N+1 (one-cycle latency).
- With `valid_i=1` and `mem_ready_i=1` held, the block completes one input and one write per cycle.
  - A frame of P pixels: the last write occurs P cycles after the first handshake, and `done_o` follows one cycle later.
- `mem_ready_i` low: `ready_o` drops combinationally in the same cycle if the output register is full.
  - `mem_we_o`, `mem_addr_o`, and `mem_data_o` must remain stable until accepted.
- Simultaneous write handshake and input handshake: the register reloads with the new pixel, and `mem_we_o` stays 1 with no bubble.
- Back-to-back frames: `start_i` in the `done_o` cycle (state is IDLE) is accepted.

## Test plan
Configuration for all scenarios: `IMG_W_P=4`, `IMG_H_P=2`, `WIDTH_P=8`, `SHIFT_P=0`.
- **Reset values:** assert `rstn_i` low mid-frame after 3 writes → all outputs are 0 asynchronously. After release, 8 new pixels are needed before `done_o`.
- **Streaming:** `start_i`, then `data_i`=0..7 with `valid_i`=1 and `mem_ready_i`=1 → writes at addr 0..7 with data 0..7 on consecutive cycles, `done_o` one cycle after the addr-7 write, `busy_o` falls with it.
- **Saturation:** `data_i`=0x00FF→0xFF, 0x0100→0xFF, 0xFFFF→0xFF, 0x0042→0x42. With `SHIFT_P=4`: 0x0FF0→0xFF, 0x1000→0xFF, 0x0420→0x42.
- **Backpressure:** `mem_ready_i` low for 3 cycles at addr 2 → `ready_o`=0, addr/data held at 2 for all 3 cycles, no pixel dropped or duplicated, final order 0..7.
- **Idle gating:** `valid_i`=1 before `start_i` → `ready_o`=0 and no writes. `start_i` pulsed in RUN → the counters do not reset and `done_o` occurs after exactly 8 writes.
- **Back-to-back frames:** `start_i` asserted in the `done_o` cycle → the second frame writes addr 0..7 and produces a second `done_o` pulse.

Source files
------------

// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - scale/saturate gradient stream and write it to frame memory in raster order
//
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   start_i                  arm one frame (sampled only in IDLE)
//   valid_i/ready_o/data_i   upstream gradient stream (2*WIDTH_P bits, unsigned)
//   mem_we_o/mem_ready_i     memory write request / accept
//   mem_addr_o, mem_data_o   write address (y*IMG_W_P + x) and saturated pixel
//   busy_o                   frame in progress (RUN or DRAIN)
//   done_o                   one-cycle pulse after the final write is accepted
module frame_writer #(
  parameter int WIDTH_P  = 8,
  parameter int IMG_W_P  = 16,
  parameter int IMG_H_P  = 16,
  parameter int SHIFT_P  = 0,
  parameter int ADDR_W_P = $clog2(IMG_W_P*IMG_H_P)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2*WIDTH_P-1:0]  data_i,
  output logic                  mem_we_o,
  input  logic                  mem_ready_i,
  output logic [ADDR_W_P-1:0]   mem_addr_o,
  output logic [WIDTH_P-1:0]    mem_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int XW_LP = (IMG_W_P > 1) ? $clog2(IMG_W_P) : 1;
  localparam int YW_LP = (IMG_H_P > 1) ? $clog2(IMG_H_P) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [XW_LP-1:0]      r_x;
  logic [YW_LP-1:0]      r_y;
  logic                  r_we;
  logic [ADDR_W_P-1:0]   r_addr;
  logic [WIDTH_P-1:0]    r_data;
  logic                  r_done;

  logic                  w_in_hs;
  logic                  w_wr_hs;
  logic                  w_last;
  logic                  w_x_wrap;
  logic [2*WIDTH_P-1:0]  w_shift;
  logic [WIDTH_P-1:0]    w_sat;
  logic [ADDR_W_P-1:0]   w_lin;

  // A full output register may still take a new pixel if it drains this cycle.
  assign ready_o  = (r_state == ST_RUN) && (!r_we || mem_ready_i);
  assign w_in_hs  = valid_i && ready_o;
  assign w_wr_hs  = r_we && mem_ready_i;

  // Any set bit above the low WIDTH_P bits after the shift means overflow.
  assign w_shift  = data_i >> SHIFT_P;
  assign w_sat    = (|w_shift[2*WIDTH_P-1:WIDTH_P]) ? {WIDTH_P{1'b1}} : w_shift[WIDTH_P-1:0];

  assign w_lin    = ADDR_W_P'(r_y) * ADDR_W_P'(IMG_W_P) + ADDR_W_P'(r_x);
  assign w_x_wrap = (r_x == XW_LP'(IMG_W_P-1));
  assign w_last   = w_x_wrap && (r_y == YW_LP'(IMG_H_P-1));

  assign mem_we_o   = r_we;
  assign mem_addr_o = r_addr;
  assign mem_data_o = r_data;
  assign busy_o     = (r_state != ST_IDLE);
  assign done_o     = r_done;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_wr_hs && !w_in_hs) begin
        r_we <= 1'b0;
      end

      if (w_in_hs) begin
        r_we   <= 1'b1;
        r_addr <= w_lin;
        r_data <= w_sat;
        if (w_x_wrap) begin
          r_x <= '0;
          // Explicit wrap keeps y in range when IMG_H_P is not a power of two.
          r_y <= w_last ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state <= ST_RUN;
            r_x     <= '0;
            r_y     <= '0;
          end
        end
        ST_RUN: begin
          if (w_in_hs && w_last) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Only the last pixel remains in the output register here.
          if (w_wr_hs) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// tb/tb_frame_writer.sv - scoreboard bench for frame_writer (4x2 frame, SHIFT 0 and 4)
module tb_frame_writer;

  localparam int PIX = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        valid;
  logic        mem_ready;
  logic [15:0] data;

  logic        ready0, we0, busy0, done0;
  logic [2:0]  addr0;
  logic [7:0]  dat0;
  logic        ready4, we4, busy4, done4;
  logic [2:0]  addr4;
  logic [7:0]  dat4;

  always #5 clk = ~clk;

  frame_writer #(.WIDTH_P(8), .IMG_W_P(4), .IMG_H_P(2), .SHIFT_P(0)) u_dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .valid_i(valid), .ready_o(ready0),
    .data_i(data), .mem_we_o(we0), .mem_ready_i(mem_ready), .mem_addr_o(addr0),
    .mem_data_o(dat0), .busy_o(busy0), .done_o(done0));

  frame_writer #(.WIDTH_P(8), .IMG_W_P(4), .IMG_H_P(2), .SHIFT_P(4)) u_dut_s4 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .valid_i(valid), .ready_o(ready4),
    .data_i(data), .mem_we_o(we4), .mem_ready_i(mem_ready), .mem_addr_o(addr4),
    .mem_data_o(dat4), .busy_o(busy4), .done_o(done4));

  typedef struct {
    logic [2:0] addr;
    logic [7:0] d0;
    logic [7:0] d4;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          m_addr = 0;
  int          cyc = 0;
  int          n_wr = 0;
  int          n_done = 0;
  int          first_wr_cyc = -1;
  int          done_cyc = 0;
  bit          exp_done = 0;
  bit          prev_stall = 0;
  logic [2:0]  prev_addr;
  logic [7:0]  prev_d0;
  logic [7:0]  prev_d4;
  logic [15:0] pix [PIX];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sat(input logic [15:0] d, input int sh);
    logic [15:0] s;
    s = d >> sh;
    return (s > 16'h00FF) ? 8'hFF : s[7:0];
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      exp_t e;
      cyc++;
      if (done0 || exp_done) begin
        check("done_pulse", 32'(done0), 32'(exp_done));
        if (exp_done) begin
          check("busy_at_done", 32'(busy0), 32'd0);
          check("writes_per_frame", 32'(n_wr), 32'd8);
          if (done0) n_done++;
          n_wr = 0;
          done_cyc = cyc;
        end
      end
      exp_done = 0;

      if (prev_stall) begin
        check("hold_addr", 32'(addr0), 32'(prev_addr));
        check("hold_data", 32'(dat0), 32'(prev_d0));
        check("hold_data_s4", 32'(dat4), 32'(prev_d4));
      end
      if (we0 && !mem_ready) check("ready_in_stall", 32'(ready0), 32'd0);
      prev_stall = we0 && !mem_ready;
      prev_addr  = addr0;
      prev_d0    = dat0;
      prev_d4    = dat4;

      if (we0 && first_wr_cyc < 0) first_wr_cyc = cyc;

      if (we0 && mem_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_write", 32'(addr0), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("wr_addr", 32'(addr0), 32'(e.addr));
          check("wr_data", 32'(dat0), 32'(e.d0));
          check("wr_data_s4", 32'(dat4), 32'(e.d4));
          n_wr++;
          if (e.addr == 3'd7) exp_done = 1;
        end
      end

      if (valid && ready0) begin
        e.addr = 3'(m_addr);
        e.d0   = sat(data, 0);
        e.d4   = sat(data, 4);
        sb.push_back(e);
        m_addr = (m_addr + 1) % PIX;
      end
    end
  end

  task automatic start_frame();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy0), 32'd1);
    check("ready_after_start", 32'(ready0), 32'd1);
  endtask

  task automatic send(input int stall_addr, input int abort_wr, input bit mid_start);
    int i = 0;
    int t = 0;
    int stalls = 0;
    bit hs = 0;
    while (i < PIX && t < 200) begin
      @(posedge clk); #1;
      t++;
      if (hs) i++;
      if (abort_wr > 0 && n_wr >= abort_wr) break;
      valid = (i < PIX);
      if (i < PIX) data = pix[i];
      start = (mid_start && i == 4) ? 1'b1 : 1'b0;
      if (stall_addr >= 0 && we0 && addr0 == 3'(stall_addr) && stalls < 3) begin
        mem_ready = 1'b0;
        stalls++;
      end else begin
        mem_ready = 1'b1;
      end
      @(negedge clk);
      hs = valid && ready0;
    end
    valid = 1'b0;
    start = 1'b0;
    mem_ready = 1'b1;
    if (t >= 200) check("send_timeout", 32'd0, 32'd1);
    if (stall_addr >= 0) check("stall_cycles", 32'(stalls), 32'd3);
  endtask

  task automatic wait_done(input bit b2b);
    int t = 0;
    int target = n_done + 1;
    while (n_done < target && t < 60) begin
      @(posedge clk); #1;
      t++;
      start = (b2b && done0) ? 1'b1 : 1'b0;
    end
    if (t >= 60) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; valid = 1'b0; mem_ready = 1'b1; data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready0), 32'd0);
    check("rst_we", 32'(we0), 32'd0);
    check("rst_addr", 32'(addr0), 32'd0);
    check("rst_data", 32'(dat0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    rstn = 1'b1;

    // Idle gating: valid without start is not accepted.
    valid = 1'b1; data = 16'h0055;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("idle_ready", 32'(ready0), 32'd0);
      check("idle_we", 32'(we0), 32'd0);
    end
    @(posedge clk); #1;
    valid = 1'b0;

    // Streaming 0..7 with one-cycle throughput.
    for (int k = 0; k < PIX; k++) pix[k] = 16'(k);
    m_addr = 0; first_wr_cyc = -1;
    start_frame();
    send(-1, 0, 0);
    wait_done(0);
    check("stream_done_latency", 32'(done_cyc - first_wr_cyc), 32'd8);

    // Saturation, observed on both shift settings.
    pix = '{16'h00FF, 16'h0100, 16'hFFFF, 16'h0042, 16'h0FF0, 16'h1000, 16'h0420, 16'h0000};
    start_frame();
    send(-1, 0, 0);
    wait_done(0);

    // Backpressure at address 2.
    for (int k = 0; k < PIX; k++) pix[k] = 16'(8'h20 + k);
    start_frame();
    send(2, 0, 0);
    wait_done(0);

    // start pulsed mid-frame must not restart the raster.
    for (int k = 0; k < PIX; k++) pix[k] = 16'(8'h30 + k);
    start_frame();
    send(-1, 0, 1);
    wait_done(0);

    // Back-to-back: start in the done cycle.
    for (int k = 0; k < PIX; k++) pix[k] = 16'(16'h0150 + 16'(k * 3));
    start_frame();
    send(-1, 0, 0);
    wait_done(1);
    check("b2b_busy", 32'(busy0), 32'd1);
    for (int k = 0; k < PIX; k++) pix[k] = 16'(8'h60 + k);
    send(-1, 0, 0);
    wait_done(0);

    // Asynchronous reset mid-frame after three writes.
    for (int k = 0; k < PIX; k++) pix[k] = 16'(8'h10 + k);
    start_frame();
    send(-1, 3, 0);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready0), 32'd0);
    check("mid_rst_we", 32'(we0), 32'd0);
    check("mid_rst_addr", 32'(addr0), 32'd0);
    check("mid_rst_data", 32'(dat0), 32'd0);
    check("mid_rst_busy", 32'(busy0), 32'd0);
    check("mid_rst_done", 32'(done0), 32'd0);
    sb.delete();
    m_addr = 0; n_wr = 0; exp_done = 0; prev_stall = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < PIX; k++) pix[k] = 16'(8'h70 + k);
    start_frame();
    send(-1, 0, 0);
    wait_done(0);

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("done_count", 32'(n_done), 32'd7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
